// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Responder side of the core's data-memory port: a word-organised RAM that
// services one load/store at a time with a fixed number of wait states and a
// single-cycle completion pulse. Handles byte/half lane selection, load
// sign/zero extension and (optionally) misaligned/reserved-size detection.
//
// Optional feature macro: DMEM_ALIGN_CHECK_EN
//   defined   : misaligned half/word and size 2'b11 are flagged as errors
//               (no RAM write, load result 0, misaligned_o with ready_o).
//   undefined : misaligned_o tied low, halves/words forced aligned,
//               size 2'b11 treated as a word access.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words (power of two, 16..65536)
//   WAIT_STATES : extra cycles between acceptance and response (0..15)
//
// Ports
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   req_i        : request valid
//   we_i         : 1 = store, 0 = load
//   size_i       : 00 byte, 01 half, 10 word, 11 reserved
//   unsigned_i   : zero-extend byte/half loads
//   address_i    : byte address
//   wdata_i      : right-aligned store data
//   rdata_o      : right-aligned, extended load result
//   ready_o      : one-cycle completion pulse
//   misaligned_o : error flag, meaningful only with ready_o
//   fsm_state    : current FSM state (0 IDLE, 1 WAIT, 2 RESP) for observation
//
// Handshake: req_i is a valid with an implicit ready -- a request is taken on
// any rising edge where the FSM is in IDLE or RESP and req_i is high. All
// request fields are captured on that edge, so the requester may change them
// afterwards. Completion is signalled by ready_o for exactly one cycle.
// -----------------------------------------------------------------------------
module data_mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [31:0] address_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        ready_o,
   output logic        misaligned_o,
   output logic [1:0]  fsm_state
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        accept;
   logic        entering_resp;

   // Latched request
   logic        lat_we;
   logic [1:0]  lat_size;
   logic        lat_unsigned;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;

   // Request fields as seen on the edge entering RESP. With zero wait states
   // that edge is also the acceptance edge, so the live inputs are used.
   logic        sel_we;
   logic [1:0]  sel_size;
   logic        sel_unsigned;
   logic [31:0] sel_addr;

   // Decoded access attributes
   logic        sel_err, lat_err;
   logic [1:0]  sel_size_e, lat_size_e;
   logic [1:0]  sel_off, lat_off;

   logic [AW-1:0] sel_idx, lat_idx;

   logic [31:0] mem [DEPTH_WORDS];

   logic [31:0] rd_word;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] load_val;

   logic [3:0]  wr_be;
   logic [31:0] wr_data;
   logic        commit;

   // Address bits above the RAM index are intentionally ignored (wrap).
   logic unused_addr_bits;

   // --------------------------------------------------------------------------
   // FSM
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_i) accept = 1'b1;
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) state_d = ST_RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ST_RESP: begin
            if (req_i) accept = 1'b1;
            else       state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (accept) begin
         if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
         end else begin
            state_d = ST_RESP;
            cnt_d   = 4'd0;
         end
      end
   end

   // A back-to-back acceptance in RESP with zero wait states re-enters RESP,
   // which counts as a fresh entry for the new request.
   assign entering_resp = (state_d == ST_RESP);
   assign ready_o       = (state_q == ST_RESP);
   assign fsm_state     = state_q;

   // --------------------------------------------------------------------------
   // Request capture and field selection
   // --------------------------------------------------------------------------
   assign sel_we       = accept ? we_i       : lat_we;
   assign sel_size     = accept ? size_i     : lat_size;
   assign sel_unsigned = accept ? unsigned_i : lat_unsigned;
   assign sel_addr     = accept ? address_i  : lat_addr;

`ifdef DMEM_ALIGN_CHECK_EN
   function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
      logic err;
      case (size)
         2'b01:   err = off[0];
         2'b10:   err = (off != 2'b00);
         2'b11:   err = 1'b1;
         default: err = 1'b0;
      endcase
      return err;
   endfunction

   assign sel_err    = access_err(sel_size, sel_addr[1:0]);
   assign lat_err    = access_err(lat_size, lat_addr[1:0]);
   assign sel_size_e = sel_size;
   assign lat_size_e = lat_size;
   assign sel_off    = sel_addr[1:0];
   assign lat_off    = lat_addr[1:0];
`else
   // Without checking, the offset is forced to the natural alignment of the
   // access so halves and words always land on their containing boundary.
   function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
      logic [1:0] o;
      case (size)
         2'b00:   o = off;
         2'b01:   o = {off[1], 1'b0};
         default: o = 2'b00;
      endcase
      return o;
   endfunction

   assign sel_err    = 1'b0;
   assign lat_err    = 1'b0;
   assign sel_size_e = (sel_size == 2'b11) ? 2'b10 : sel_size;
   assign lat_size_e = (lat_size == 2'b11) ? 2'b10 : lat_size;
   assign sel_off    = align_off(sel_size_e, sel_addr[1:0]);
   assign lat_off    = align_off(lat_size_e, lat_addr[1:0]);
`endif

   assign sel_idx = sel_addr[AW+1:2];
   assign lat_idx = lat_addr[AW+1:2];

   assign unused_addr_bits = ^{sel_addr[31:AW+2], lat_addr[31:AW+2]};

   // --------------------------------------------------------------------------
   // Load path: RAM is read on the edge entering RESP, never at acceptance
   // (unless they coincide with zero wait states).
   // --------------------------------------------------------------------------
   always_comb begin
      rd_word = mem[sel_idx];
      case (sel_off)
         2'd0:    rd_byte = rd_word[7:0];
         2'd1:    rd_byte = rd_word[15:8];
         2'd2:    rd_byte = rd_word[23:16];
         default: rd_byte = rd_word[31:24];
      endcase
      rd_half = sel_off[1] ? rd_word[31:16] : rd_word[15:0];
      case (sel_size_e)
         2'b00:   load_val = sel_unsigned ? {24'd0, rd_byte}
                                          : {{24{rd_byte[7]}}, rd_byte};
         2'b01:   load_val = sel_unsigned ? {16'd0, rd_half}
                                          : {{16{rd_half[15]}}, rd_half};
         default: load_val = rd_word;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_we       <= 1'b0;
         lat_size     <= 2'b00;
         lat_unsigned <= 1'b0;
         lat_addr     <= 32'd0;
         lat_wdata    <= 32'd0;
         rdata_o      <= 32'd0;
         misaligned_o <= 1'b0;
      end else begin
         if (accept) begin
            lat_we       <= we_i;
            lat_size     <= size_i;
            lat_unsigned <= unsigned_i;
            lat_addr     <= address_i;
            lat_wdata    <= wdata_i;
         end
         misaligned_o <= entering_resp & sel_err;
         // Only loads update the result register; stores leave it untouched.
         if (entering_resp && !sel_we) begin
            rdata_o <= sel_err ? 32'd0 : load_val;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Store path: commits on the edge that ends RESP, using latched fields.
   // --------------------------------------------------------------------------
   always_comb begin
      wr_be   = 4'b0000;
      wr_data = lat_wdata;
      case (lat_size_e)
         2'b00: begin
            wr_be   = 4'b0001 << lat_off;
            wr_data = {4{lat_wdata[7:0]}};
         end
         2'b01: begin
            wr_be   = lat_off[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{lat_wdata[15:0]}};
         end
         default: begin
            wr_be   = 4'b1111;
            wr_data = lat_wdata;
         end
      endcase
   end

   // state_q is reset asynchronously, so a reset mid-transaction can never
   // reach a commit.
   assign commit = (state_q == ST_RESP) && lat_we && !lat_err;

   always_ff @(posedge clk) begin
      if (commit) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) mem[lat_idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Directed bench for data_mem_responder. Three instances share the request
// fields and clock/reset but have their own req and outputs:
//   sel 0 : DEPTH 1024, 2 wait states
//   sel 1 : DEPTH 1024, 0 wait states
//   sel 2 : DEPTH 16,   1 wait state
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

   // ---------------------------------------------------------------- clock/reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------- DUT signals
   logic        we = 1'b0;
   logic [1:0]  size = 2'b00;
   logic        uns = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;

   logic        req_w2 = 1'b0, req_w0 = 1'b0, req_d16 = 1'b0;
   logic [31:0] rdata_w2, rdata_w0, rdata_d16;
   logic        ready_w2, ready_w0, ready_d16;
   logic        mis_w2, mis_w0, mis_d16;
   logic [1:0]  state_w2, state_w0, state_d16;

   int n_checks = 0;
   int n_pass   = 0;

   data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u_w2 (
      .clk(clk), .rst_n(rst_n), .req_i(req_w2), .we_i(we), .size_i(size),
      .unsigned_i(uns), .address_i(addr), .wdata_i(wdata), .rdata_o(rdata_w2),
      .ready_o(ready_w2), .misaligned_o(mis_w2), .fsm_state(state_w2)
   );

   data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_w0 (
      .clk(clk), .rst_n(rst_n), .req_i(req_w0), .we_i(we), .size_i(size),
      .unsigned_i(uns), .address_i(addr), .wdata_i(wdata), .rdata_o(rdata_w0),
      .ready_o(ready_w0), .misaligned_o(mis_w0), .fsm_state(state_w0)
   );

   data_mem_responder #(.DEPTH_WORDS(16), .WAIT_STATES(1)) u_d16 (
      .clk(clk), .rst_n(rst_n), .req_i(req_d16), .we_i(we), .size_i(size),
      .unsigned_i(uns), .address_i(addr), .wdata_i(wdata), .rdata_o(rdata_d16),
      .ready_o(ready_d16), .misaligned_o(mis_d16), .fsm_state(state_d16)
   );

   // ---------------------------------------------------------------- helpers
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   function automatic logic rdy_of(input int sel);
      case (sel)
         0:       return ready_w2;
         1:       return ready_w0;
         default: return ready_d16;
      endcase
   endfunction

   function automatic logic [31:0] rd_of(input int sel);
      case (sel)
         0:       return rdata_w2;
         1:       return rdata_w0;
         default: return rdata_d16;
      endcase
   endfunction

   function automatic logic mis_of(input int sel);
      case (sel)
         0:       return mis_w2;
         1:       return mis_w0;
         default: return mis_d16;
      endcase
   endfunction

   task automatic set_req(input int sel, input logic v);
      case (sel)
         0:       req_w2  = v;
         1:       req_w0  = v;
         default: req_d16 = v;
      endcase
   endtask

   task automatic drive(input logic w, input logic [1:0] s, input logic u,
                        input logic [31:0] a, input logic [31:0] d);
      we = w; size = s; uns = u; addr = a; wdata = d;
   endtask

   // Issue one request, scramble the fields after acceptance, wait for the
   // ready pulse (bounded) and let the RESP cycle finish.
   task automatic do_req(input int sel, input logic w, input logic [1:0] s,
                         input logic u, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rd, output logic ms);
      drive(w, s, u, a, d);
      set_req(sel, 1'b1);
      @(posedge clk); #1;
      set_req(sel, 1'b0);
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom, $urandom);
      lat = 1;
      while (!rdy_of(sel) && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!rdy_of(sel)) check("ready_timeout", 32'd0, 32'd1);
      rd = rd_of(sel);
      ms = mis_of(sel);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- stimulus
   initial begin
      int          lat;
      logic [31:0] rd;
      logic        ms;
      logic [31:0] ext_addr [4];
      logic [1:0]  ext_size [4];
      logic        ext_uns  [4];
      logic [31:0] ext_exp  [4];

      ext_addr = '{32'h12, 32'h12, 32'h12, 32'h10};
      ext_size = '{2'b00, 2'b00, 2'b01, 2'b01};
      ext_uns  = '{1'b0, 1'b1, 1'b0, 1'b1};
      ext_exp  = '{32'hFFFFFFF1, 32'h000000F1, 32'hFFFF80F1, 32'h00007F00};

      // Reset values
      #2;
      check("rst_ready_w2", 32'(ready_w2), 32'd0);
      check("rst_rdata_w2", rdata_w2, 32'd0);
      check("rst_mis_w2",   32'(mis_w2), 32'd0);
      check("rst_ready_w0", 32'(ready_w0), 32'd0);
      check("rst_rdata_d16", rdata_d16, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Word store/load, two wait states
      do_req(0, 1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF, lat, rd, ms);
      check("w2_store_latency", 32'(lat), 32'd3);
      check("w2_store_mis", 32'(ms), 32'd0);
      do_req(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, rd, ms);
      check("w2_load_latency", 32'(lat), 32'd3);
      check("w2_load_data", rd, 32'hDEADBEEF);

      // Byte/half extension
      do_req(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h80F17F00, lat, rd, ms);
      for (int i = 0; i < 4; i++) begin
         do_req(0, 1'b0, ext_size[i], ext_uns[i], ext_addr[i], 32'h0, lat, rd, ms);
         check($sformatf("ext_load_%0d", i), rd, ext_exp[i]);
      end
      do_req(0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h123456AA, lat, rd, ms);
      check("store_keeps_rdata", rd, 32'h00007F00);
      do_req(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, ms);
      check("sb_lane1_word", rd, 32'h80F1AA00);
      do_req(0, 1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF1234, lat, rd, ms);
      do_req(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, ms);
      check("sh_upper_word", rd, 32'h1234AA00);

      // Reset asserted mid-WAIT with a store pending
      do_req(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, rd, ms);
      check("pre_reset_load", rd, 32'hDEADBEEF);
      drive(1'b1, 2'b10, 1'b0, 32'h40, 32'h11111111);
      req_w2 = 1'b1;
      @(posedge clk); #1;
      req_w2 = 1'b0;
      check("mid_wait_state", 32'(state_w2), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_rdata", rdata_w2, 32'd0);
      check("async_rst_ready", 32'(ready_w2), 32'd0);
      check("async_rst_mis",   32'(mis_w2), 32'd0);
      check("async_rst_state", 32'(state_w2), 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      do_req(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, rd, ms);
      check("dropped_store_old_data", rd, 32'hDEADBEEF);

      // Zero wait states: latency and back-to-back
      do_req(1, 1'b1, 2'b10, 1'b0, 32'h104, 32'h00000055, lat, rd, ms);
      check("w0_latency", 32'(lat), 32'd1);
      drive(1'b1, 2'b10, 1'b0, 32'h100, 32'hA1A1A1A1);
      req_w0 = 1'b1;
      @(posedge clk); #1;
      check("b2b_ready0", 32'(ready_w0), 32'd1);
      drive(1'b0, 2'b10, 1'b0, 32'h104, 32'h0);
      @(posedge clk); #1;
      check("b2b_ready1", 32'(ready_w0), 32'd1);
      check("b2b_load1", rdata_w0, 32'h00000055);
      drive(1'b1, 2'b10, 1'b0, 32'h104, 32'hB2B2B2B2);
      @(posedge clk); #1;
      check("b2b_ready2", 32'(ready_w0), 32'd1);
      drive(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
      @(posedge clk); #1;
      check("b2b_ready3", 32'(ready_w0), 32'd1);
      check("b2b_load3", rdata_w0, 32'hA1A1A1A1);
      req_w0 = 1'b0;
      @(posedge clk); #1;
      check("b2b_ready_end", 32'(ready_w0), 32'd0);

      // Read-after-write, zero wait states: load sees pre-store data
      do_req(1, 1'b1, 2'b10, 1'b0, 32'h200, 32'h00000077, lat, rd, ms);
      drive(1'b1, 2'b10, 1'b0, 32'h200, 32'h00000099);
      req_w0 = 1'b1;
      @(posedge clk); #1;
      drive(1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
      @(posedge clk); #1;
      req_w0 = 1'b0;
      check("raw_w0_old_data", rdata_w0, 32'h00000077);
      @(posedge clk); #1;
      do_req(1, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, lat, rd, ms);
      check("raw_w0_later_new", rd, 32'h00000099);

      // Read-after-write, one wait state: load sees new data
      drive(1'b1, 2'b10, 1'b0, 32'h08, 32'hAAAA5555);
      req_d16 = 1'b1;
      @(posedge clk); #1;
      req_d16 = 1'b0;
      @(posedge clk); #1;
      check("raw_d16_store_ready", 32'(ready_d16), 32'd1);
      drive(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
      req_d16 = 1'b1;
      @(posedge clk); #1;
      req_d16 = 1'b0;
      check("raw_d16_wait", 32'(ready_d16), 32'd0);
      @(posedge clk); #1;
      check("raw_d16_load_ready", 32'(ready_d16), 32'd1);
      check("raw_d16_new_data", rdata_d16, 32'hAAAA5555);
      @(posedge clk); #1;

      // Address wrap, 16-word RAM
      do_req(2, 1'b1, 2'b10, 1'b0, 32'h40, 32'h00001234, lat, rd, ms);
      check("d16_latency", 32'(lat), 32'd2);
      do_req(2, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, lat, rd, ms);
      check("wrap_load", rd, 32'h00001234);

      // Misaligned / reserved size
      do_req(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h13572468, lat, rd, ms);
      do_req(0, 1'b1, 2'b10, 1'b0, 32'h24, 32'h0BADF00D, lat, rd, ms);
      do_req(0, 1'b1, 2'b10, 1'b0, 32'h22, 32'hCAFEF00D, lat, rd, ms);
`ifdef DMEM_ALIGN_CHECK_EN
      check("sw_misaligned_flag", 32'(ms), 32'd1);
      do_req(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, rd, ms);
      check("sw_misaligned_no_write", rd, 32'h13572468);
      do_req(0, 1'b0, 2'b01, 1'b0, 32'h21, 32'h0, lat, rd, ms);
      check("lh_misaligned_data", rd, 32'h0);
      check("lh_misaligned_flag", 32'(ms), 32'd1);
      do_req(0, 1'b0, 2'b10, 1'b0, 32'h24, 32'h0, lat, rd, ms);
      check("aligned_load_after_err", rd, 32'h0BADF00D);
      check("aligned_load_flag", 32'(ms), 32'd0);
      do_req(0, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, lat, rd, ms);
      check("reserved_size_data", rd, 32'h0);
      check("reserved_size_flag", 32'(ms), 32'd1);
`else
      check("sw_misaligned_flag", 32'(ms), 32'd0);
      do_req(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, rd, ms);
      check("sw_forced_aligned", rd, 32'hCAFEF00D);
      do_req(0, 1'b0, 2'b01, 1'b0, 32'h21, 32'h0, lat, rd, ms);
      check("lh_forced_aligned", rd, 32'hFFFFF00D);
      check("lh_flag_low", 32'(ms), 32'd0);
      do_req(0, 1'b0, 2'b10, 1'b0, 32'h24, 32'h0, lat, rd, ms);
      check("aligned_load", rd, 32'h0BADF00D);
      do_req(0, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, lat, rd, ms);
      check("reserved_as_word", rd, 32'hCAFEF00D);
      check("reserved_flag_low", 32'(ms), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
